// File: rtl/i2si_sample_fifo.sv
// i2si_sample_fifo: stereo sample FIFO behind the I2S deserializer.
// Queues left/right pairs on strobe rise, drains via valid/ready.
module i2si_sample_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int AFULL_LVL = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_i2si_en,
  input  logic [15:0]   i2si_lft,
  input  logic [15:0]   i2si_rgt,
  input  logic          i2si_xfc,
  input  logic          fifo_rdy,
  input  logic          ovf_clr,
  output logic          fifo_valid,
  output logic [15:0]   fifo_lft,
  output logic [15:0]   fifo_rgt,
  output logic [AW:0]   fifo_level,
  output logic          fifo_afull,
  output logic          ovf,
  output logic [7:0]    ovf_cnt
);

  localparam logic [AW:0] L_FULL  = DEPTH[AW:0];
  localparam logic [AW:0] L_AFULL = AFULL_LVL[AW:0];

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_xfc_q;
  logic          r_ovf;
  logic [7:0]    r_ovf_cnt;

  logic          w_push_req;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_drop;
  logic          w_wr_en;
  logic [31:0]   w_head;

  assign w_push_req = i2si_xfc & ~r_xfc_q & rf_i2si_en;
  assign w_full     = (r_level == L_FULL);
  assign w_valid    = (r_level != '0);
  assign w_pop      = w_valid & fifo_rdy & rf_i2si_en;
  // A full FIFO only makes room when the head leaves this cycle.
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_wr_en    = w_push_req & ~w_drop;
  assign w_head     = r_mem[r_rd_ptr];

  // Previous strobe level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfc_q <= 1'b0;
    end else begin
      r_xfc_q <= i2si_xfc;
    end
  end

  // Sample storage; contents survive a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {i2si_lft, i2si_rgt};
    end
  end

  // Pointers and fill level; disable acts as a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (!rf_i2si_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (ovf_clr) begin
        r_ovf_cnt <= 8'd1;
      end else if (r_ovf_cnt != 8'hFF) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end
  end

  assign fifo_valid = w_valid;
  assign fifo_lft   = w_head[31:16];
  assign fifo_rgt   = w_head[15:0];
  assign fifo_level = r_level;
  assign fifo_afull = (r_level >= L_AFULL);
  assign ovf        = r_ovf;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_i2si_sample_fifo.sv
// tb_i2si_sample_fifo: vectors, directed corners and random traffic
// checked against a queue-based model of the sample FIFO.
module tb_i2si_sample_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AFL   = 6;

  logic        clk;
  logic        rst;
  logic        rf_i2si_en;
  logic [15:0] i2si_lft;
  logic [15:0] i2si_rgt;
  logic        i2si_xfc;
  logic        fifo_rdy;
  logic        ovf_clr;
  logic        fifo_valid;
  logic [15:0] fifo_lft;
  logic [15:0] fifo_rgt;
  logic [AW:0] fifo_level;
  logic        fifo_afull;
  logic        ovf;
  logic [7:0]  ovf_cnt;

  i2si_sample_fifo #(
    .DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFL)
  ) dut (
    .clk(clk), .rst(rst), .rf_i2si_en(rf_i2si_en),
    .i2si_lft(i2si_lft), .i2si_rgt(i2si_rgt),
    .i2si_xfc(i2si_xfc), .fifo_rdy(fifo_rdy),
    .ovf_clr(ovf_clr), .fifo_valid(fifo_valid),
    .fifo_lft(fifo_lft), .fifo_rgt(fifo_rgt),
    .fifo_level(fifo_level), .fifo_afull(fifo_afull),
    .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_q[$];
  logic        m_xfc;
  logic        m_ovf;
  int          m_cnt;

  typedef struct {
    logic        xfc;
    logic [15:0] l;
    logic [15:0] r;
    logic        rdy;
    int          lvl;
    logic        vld;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_xfc = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic xfc, input logic [15:0] l,
                            input logic [15:0] r, input logic rdy,
                            input logic en, input logic clr);
    logic push, pop, drop;
    push = xfc & ~m_xfc & en;
    pop  = (m_q.size() != 0) & rdy;
    drop = 1'b0;
    m_xfc = xfc;
    if (!en) begin
      m_q.delete();
    end else begin
      if (push && m_q.size() == DEPTH && !pop) drop = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back({l, r});
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(fifo_valid), 32'(m_q.size() != 0));
    chk("level", 32'(fifo_level), 32'(m_q.size()));
    chk("afull", 32'(fifo_afull), 32'(m_q.size() >= AFL));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    if (m_q.size() != 0) begin
      chk("head_lft", 32'(fifo_lft), 32'(m_q[0][31:16]));
      chk("head_rgt", 32'(fifo_rgt), 32'(m_q[0][15:0]));
    end
  endtask

  task automatic cyc(input logic xfc, input logic [15:0] l,
                     input logic [15:0] r, input logic rdy,
                     input logic en, input logic clr);
    i2si_xfc   = xfc;
    i2si_lft   = l;
    i2si_rgt   = r;
    fifo_rdy   = rdy;
    rf_i2si_en = en;
    ovf_clr    = clr;
    @(posedge clk);
    model_step(xfc, l, r, rdy, en, clr);
    #1;
    check_model();
  endtask

  task automatic push(input logic [15:0] k, input logic rdy);
    logic [15:0] nk;
    nk = ~k;
    cyc(1'b1, k, nk, rdy, 1'b1, 1'b0);
    cyc(1'b0, k, nk, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop_chk(input logic [15:0] k);
    logic [15:0] nk;
    nk = ~k;
    chk("pop_valid", 32'(fifo_valid), 32'd1);
    chk("pop_lft", 32'(fifo_lft), 32'(k));
    chk("pop_rgt", 32'(fifo_rgt), 32'(nk));
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, 32'(fifo_valid), 32'd0);
    chk({nm, "_lft"}, 32'(fifo_lft), 32'd0);
    chk({nm, "_rgt"}, 32'(fifo_rgt), 32'd0);
    chk({nm, "_level"}, 32'(fifo_level), 32'd0);
    chk({nm, "_afull"}, 32'(fifo_afull), 32'd0);
    chk({nm, "_ovf"}, 32'(ovf), 32'd0);
    chk({nm, "_cnt"}, 32'(ovf_cnt), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 1, 1'b1, 16'hA5A5, 16'h5A5A};
    tbl[1] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 1, 1'b1, 16'hA5A5, 16'h5A5A};
    tbl[2] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 1, 1'b1, 16'hA5A5, 16'h5A5A};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1, 1'b1, 16'hA5A5, 16'h5A5A};
    tbl[4] = '{1'b1, 16'h1111, 16'h2222, 1'b1, 1, 1'b1, 16'h1111, 16'h2222};
    tbl[5] = '{1'b1, 16'h3333, 16'h4444, 1'b1, 0, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 16'h0000};
    tbl[7] = '{1'b1, 16'hBEEF, 16'hCAFE, 1'b1, 1, 1'b1, 16'hBEEF, 16'hCAFE};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 16'h0000};

    rst = 1'b0;
    rf_i2si_en = 1'b1;
    i2si_lft = '0;
    i2si_rgt = '0;
    i2si_xfc = 1'b0;
    fifo_rdy = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].xfc, tbl[i].l, tbl[i].r, tbl[i].rdy, 1'b1, 1'b0);
      chk($sformatf("tv%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("tv%0d_valid", i), 32'(fifo_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tv%0d_lft", i), 32'(fifo_lft), 32'(tbl[i].el));
        chk($sformatf("tv%0d_rgt", i), 32'(fifo_rgt), 32'(tbl[i].er));
      end
    end

    for (int k = 0; k < 8; k++) begin
      push(16'(k), 1'b0);
      chk("fill_afull", 32'(fifo_afull), 32'(k + 1 >= AFL));
    end
    chk("fill_level", 32'(fifo_level), 32'd8);
    for (int k = 0; k < 4; k++) pop_chk(16'(k));
    for (int k = 8; k < 12; k++) push(16'(k), 1'b0);
    chk("wrap_level", 32'(fifo_level), 32'd8);
    for (int k = 4; k < 12; k++) pop_chk(16'(k));
    chk("wrap_empty", 32'(fifo_level), 32'd0);

    for (int k = 0; k < 8; k++) push(16'(8'h30 + k), 1'b0);
    for (int k = 0; k < 3; k++) push(16'h00EE, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_cnt3", 32'(ovf_cnt), 32'd3);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    cyc(1'b1, 16'h00EE, 16'hFF11, 1'b0, 1'b1, 1'b1);
    chk("clr_drop_ovf", 32'(ovf), 32'd1);
    chk("clr_drop_cnt", 32'(ovf_cnt), 32'd1);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 260; k++) push(16'h00EE, 1'b0);
    chk("cnt_sat", 32'(ovf_cnt), 32'd255);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);

    push(16'd20, 1'b1);
    chk("fullpp_level", 32'(fifo_level), 32'd8);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    for (int k = 1; k < 8; k++) pop_chk(16'(8'h30 + k));
    pop_chk(16'd20);
    chk("fullpp_empty", 32'(fifo_level), 32'd0);

    for (int k = 0; k < 9; k++) push(16'(8'h40 + k), 1'b0);
    for (int k = 0; k < 3; k++) pop_chk(16'(8'h40 + k));
    chk("pre_flush_level", 32'(fifo_level), 32'd5);
    chk("pre_flush_ovf", 32'(ovf), 32'd1);
    cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_valid", 32'(fifo_valid), 32'd0);
    chk("flush_ovf", 32'(ovf), 32'd1);
    chk("flush_cnt", 32'(ovf_cnt), 32'd1);
    cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b0);
    chk("post_flush_level", 32'(fifo_level), 32'd0);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) push(16'(8'h50 + k), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    i2si_xfc = 1'b1;
    i2si_lft = 16'h7777;
    i2si_rgt = 16'h8888;
    @(posedge clk);
    #2;
    rst = 1'b1;
    cyc(1'b1, 16'h7777, 16'h8888, 1'b0, 1'b1, 1'b0);
    chk("rel_level", 32'(fifo_level), 32'd1);
    cyc(1'b1, 16'h7777, 16'h8888, 1'b0, 1'b1, 1'b0);
    chk("rel_once", 32'(fifo_level), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      if (i < 1500) rdy = ($urandom_range(0, 3) == 0);
      else          rdy = ($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
          rdy, ($urandom_range(0, 63) != 0),
          ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
